// File: rtl/tdm_pkg.sv
`default_nettype none
// ============================================================================
// Module  : tdm_pkg
// Purpose : Shared definitions for the 8-channel TDM link (transmit mux and
//           receive demux). Frame geometry and receiver FSM state encodings.
// Contents: CHANNELS    - slots per frame (fixed at 8)
//           SEL_W       - slot index width, log2(CHANNELS)
//           tdm_state_t - receiver lock FSM states
// Revision: 1.0 - initial release
// ============================================================================
package tdm_pkg;

  localparam int CHANNELS = 8;
  localparam int SEL_W    = 3;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    CONFIRM = 2'd1,
    LOCKED  = 2'd2
  } tdm_state_t;

endpackage
`default_nettype wire

// File: rtl/tdm_slot_counter.sv
`default_nettype none
// ============================================================================
// Module  : tdm_slot_counter
// Purpose : Slot index tracker for the TDM receiver. Holds the slot expected
//           on the next valid beat and flags the first and last slot.
// Ports   : clk      in  1      rising-edge clock
//           rst      in  1      synchronous active-high reset (s <= 0)
//           en       in  1      advance by one slot, wrapping last -> 0
//           clr      in  1      force slot 0 (highest priority after rst)
//           load1    in  1      force slot 1 (beat just taken as slot 0)
//           s        out SEL_W  current slot index
//           at_start out 1      s is slot 0
//           at_last  out 1      s is the last slot of the frame
// Revision: 1.0 - initial release
// ============================================================================
module tdm_slot_counter
  import tdm_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             load1,
  output logic [SEL_W-1:0] s,
  output logic             at_start,
  output logic             at_last
);

  localparam logic [SEL_W-1:0] c_last = SEL_W'(CHANNELS - 1);

  logic [SEL_W-1:0] r_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s <= '0;
    end else if (clr) begin
      r_s <= '0;
    end else if (load1) begin
      r_s <= SEL_W'(1);
    end else if (en) begin
      // Natural power-of-two wrap takes the last slot back to 0.
      r_s <= r_s + SEL_W'(1);
    end
  end

  assign s        = r_s;
  assign at_start = (r_s == '0);
  assign at_last  = (r_s == c_last);

endmodule
`default_nettype wire

// File: rtl/tdm_demux_8ch.sv
`default_nettype none
// ============================================================================
// Module  : tdm_demux_8ch
// Purpose : Receive side of the 8-channel TDM link. Tracks the slot index,
//           acquires and holds frame lock with a hysteresis FSM
//           (HUNT -> CONFIRM -> LOCKED), and reassembles each frame into a
//           parallel word where slot k lands in y[k].
// Params  : LOCK_FRAMES - consecutive aligned fsyncs to enter LOCKED (1..7)
//           LOSS_FRAMES - consecutive missing/misplaced fsyncs to drop (1..7)
// Ports   : clk       in  1      rising-edge clock
//           rst       in  1      synchronous active-high reset
//           din       in  1      serial slot data
//           din_valid in  1      beat qualifier
//           fsync     in  1      frame marker, high on the slot-0 beat
//           y         out 8      last completed frame
//           y_valid   out 1      one-cycle pulse when y updates
//           s         out SEL_W  slot expected on the next valid beat
//           locked    out 1      FSM is in LOCKED
//           sync_err  out 1      one-cycle pulse on a bad fsync while LOCKED
// Revision: 1.0 - initial release
// ============================================================================
module tdm_demux_8ch
  import tdm_pkg::*;
#(
  parameter int LOCK_FRAMES = 2,
  parameter int LOSS_FRAMES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                din,
  input  logic                din_valid,
  input  logic                fsync,
  output logic [CHANNELS-1:0] y,
  output logic                y_valid,
  output logic [SEL_W-1:0]    s,
  output logic                locked,
  output logic                sync_err
);

  localparam logic [2:0] c_lock_frames = 3'(LOCK_FRAMES);
  localparam logic [2:0] c_loss_frames = 3'(LOSS_FRAMES);

  tdm_state_t          r_state;
  logic [2:0]          r_good_cnt;
  logic [2:0]          r_miss_cnt;
  // The last slot never needs storing: it goes straight from din into y.
  logic [CHANNELS-2:0] r_asm;
  logic [CHANNELS-1:0] r_y;
  logic                r_y_valid;
  logic                r_locked;
  logic                r_sync_err;

  logic [SEL_W-1:0]    w_s;
  logic                w_at_start;
  logic                w_at_last;
  logic [2:0]          w_good_inc;
  logic [2:0]          w_miss_inc;
  logic                w_miss;
  logic                w_loss;
  logic                w_clr;
  logic                w_load1;
  logic                w_adv;
  logic                w_emit;

  assign w_good_inc = r_good_cnt + 3'd1;
  assign w_miss_inc = r_miss_cnt + 3'd1;

  // A bad marker is either fsync absent on slot 0 or present on any other
  // slot, i.e. fsync disagrees with at_start.
  assign w_miss = w_at_start ^ fsync;
  assign w_loss = w_miss && (w_miss_inc == c_loss_frames);

  // Slot counter control, decoded from the same conditions the FSM uses.
  always_comb begin
    w_clr   = 1'b0;
    w_load1 = 1'b0;
    w_adv   = 1'b0;
    w_emit  = 1'b0;
    if (din_valid) begin
      case (r_state)
        HUNT: begin
          w_load1 = fsync;
        end
        CONFIRM: begin
          if (w_at_start && !fsync) begin
            w_clr = 1'b1;
          end else if (!w_at_start && fsync) begin
            w_load1 = 1'b1;
          end else begin
            w_adv = 1'b1;
          end
        end
        LOCKED: begin
          // Flywheel: a bad marker only advances, unless it is the one that
          // drops lock, in which case the beat is thrown away.
          if (w_loss) begin
            w_clr = 1'b1;
          end else begin
            w_adv  = 1'b1;
            w_emit = w_at_last;
          end
        end
        default: begin
          w_clr = 1'b1;
        end
      endcase
    end
  end

  tdm_slot_counter u_slot_counter (
    .clk      (clk),
    .rst      (rst),
    .en       (w_adv),
    .clr      (w_clr),
    .load1    (w_load1),
    .s        (w_s),
    .at_start (w_at_start),
    .at_last  (w_at_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= HUNT;
      r_good_cnt <= '0;
      r_miss_cnt <= '0;
      r_asm      <= '0;
      r_y        <= '0;
      r_y_valid  <= 1'b0;
      r_locked   <= 1'b0;
      r_sync_err <= 1'b0;
    end else begin
      r_y_valid  <= 1'b0;
      r_sync_err <= 1'b0;

      if (w_load1) begin
        r_asm[0] <= din;
      end else if (w_adv && !w_at_last) begin
        r_asm[w_s] <= din;
      end

      if (w_emit) begin
        r_y       <= {din, r_asm};
        r_y_valid <= 1'b1;
      end

      if (din_valid) begin
        case (r_state)
          HUNT: begin
            if (fsync) begin
              r_good_cnt <= 3'd1;
              if (c_lock_frames == 3'd1) begin
                r_state    <= LOCKED;
                r_locked   <= 1'b1;
                r_miss_cnt <= '0;
              end else begin
                r_state <= CONFIRM;
              end
            end
          end
          CONFIRM: begin
            if (w_at_start) begin
              if (fsync) begin
                r_good_cnt <= w_good_inc;
                if (w_good_inc == c_lock_frames) begin
                  r_state    <= LOCKED;
                  r_locked   <= 1'b1;
                  r_miss_cnt <= '0;
                end
              end else begin
                r_state <= HUNT;
              end
            end else if (fsync) begin
              // Realign onto the marker just seen.
              r_good_cnt <= 3'd1;
            end
          end
          LOCKED: begin
            if (w_miss) begin
              r_sync_err <= 1'b1;
              if (w_loss) begin
                r_state    <= HUNT;
                r_locked   <= 1'b0;
                r_miss_cnt <= '0;
              end else begin
                r_miss_cnt <= w_miss_inc;
              end
            end else if (w_at_start) begin
              r_miss_cnt <= '0;
            end
          end
          default: begin
            r_state  <= HUNT;
            r_locked <= 1'b0;
          end
        endcase
      end
    end
  end

  assign y        = r_y;
  assign y_valid  = r_y_valid;
  assign s        = w_s;
  assign locked   = r_locked;
  assign sync_err = r_sync_err;

endmodule
`default_nettype wire

// File: tb/tb_tdm_demux_8ch.sv
`default_nettype none
// ============================================================================
// Module  : tb_tdm_demux_8ch
// Purpose : Directed self-checking bench for tdm_demux_8ch: reset, frame
//           acquisition, gapped beats, misplaced and missing markers, loss
//           of lock and reset in the middle of a locked frame.
// Revision: 1.0 - initial release
// ============================================================================
module tb_tdm_demux_8ch;

  logic       clk;
  logic       rst;
  logic       din;
  logic       din_valid;
  logic       fsync;
  logic [7:0] y;
  logic       y_valid;
  logic [2:0] s;
  logic       locked;
  logic       sync_err;

  int         checks;
  int         errors;
  int         n_yv;
  int         n_se;
  logic [7:0] last_y;

  tdm_demux_8ch #(
    .LOCK_FRAMES (2),
    .LOSS_FRAMES (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .fsync     (fsync),
    .y         (y),
    .y_valid   (y_valid),
    .s         (s),
    .locked    (locked),
    .sync_err  (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic sample();
    if (y_valid) begin
      n_yv++;
      last_y = y;
    end
    if (sync_err) n_se++;
  endtask

  task automatic clear_counts();
    n_yv = 0;
    n_se = 0;
  endtask

  task automatic send_beat(input logic b, input logic f);
    @(negedge clk);
    din       = b;
    fsync     = f;
    din_valid = 1'b1;
    @(posedge clk);
    #1;
    sample();
  endtask

  // Idle cycles carry random din/fsync, which the design must ignore.
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      din_valid = 1'b0;
      din       = 1'($urandom);
      fsync     = 1'($urandom);
      @(posedge clk);
      #1;
      sample();
    end
  endtask

  task automatic send_frame(input logic [7:0] v, input logic [7:0] fmask);
    for (int i = 0; i < 8; i++) send_beat(v[i], fmask[i]);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      din_valid = 1'b1;
      din       = 1'($urandom);
      fsync     = 1'($urandom);
      @(posedge clk);
      #1;
    end
    checks++; if (y !== 8'h00)     begin errors++; $display("FAIL reset_y: got %h required %h", y, 8'h00); end
    checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL reset_y_valid: got %b required 0", y_valid); end
    checks++; if (s !== 3'd0)       begin errors++; $display("FAIL reset_s: got %0d required 0", s); end
    checks++; if (locked !== 1'b0)  begin errors++; $display("FAIL reset_locked: got %b required 0", locked); end
    checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL reset_sync_err: got %b required 0", sync_err); end
    @(negedge clk);
    rst       = 1'b0;
    din_valid = 1'b0;
  endtask

  task automatic test_acquire(input logic [7:0] f1, input logic [7:0] f2, input string tag);
    clear_counts();
    send_frame(f1, 8'h01);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL %s_locked_after_f1: got %b required 0", tag, locked); end
    checks++; if (s !== 3'd0)      begin errors++; $display("FAIL %s_s_after_f1: got %0d required 0", tag, s); end
    checks++; if (n_yv !== 0)      begin errors++; $display("FAIL %s_no_pulse_f1: got %0d pulses required 0", tag, n_yv); end
    for (int i = 0; i < 8; i++) begin
      send_beat(f2[i], i == 0);
      if (i == 0) begin
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL %s_locked_rise: got %b required 1", tag, locked); end
      end
    end
    checks++; if (y_valid !== 1'b1) begin errors++; $display("FAIL %s_y_valid: got %b required 1", tag, y_valid); end
    checks++; if (y !== f2)         begin errors++; $display("FAIL %s_y: got %h required %h", tag, y, f2); end
    idle(1);
    checks++; if (n_yv !== 1)       begin errors++; $display("FAIL %s_pulse_count: got %0d required 1", tag, n_yv); end
  endtask

  task automatic test_gaps();
    logic [7:0] v;
    v = 8'h5A;
    clear_counts();
    for (int i = 0; i < 8; i++) begin
      send_beat(v[i], i == 0);
      if (i == 7) begin
        checks++; if (y_valid !== 1'b1) begin errors++; $display("FAIL gaps_y_valid_latency: got %b required 1", y_valid); end
        checks++; if (y !== 8'h5A)      begin errors++; $display("FAIL gaps_y: got %h required 5a", y); end
      end
      idle(1 + (i % 3));
      checks++; if (s !== 3'((i + 1) % 8)) begin errors++; $display("FAIL gaps_s_hold_%0d: got %0d required %0d", i, s, (i + 1) % 8); end
    end
    checks++; if (n_yv !== 1) begin errors++; $display("FAIL gaps_pulse_count: got %0d required 1", n_yv); end
  endtask

  task automatic test_misplaced_fsync();
    clear_counts();
    send_frame(8'h0F, 8'b0000_1001);
    idle(1);
    checks++; if (n_se !== 1)       begin errors++; $display("FAIL misplaced_sync_err: got %0d pulses required 1", n_se); end
    checks++; if (locked !== 1'b1)  begin errors++; $display("FAIL misplaced_locked: got %b required 1", locked); end
    checks++; if (n_yv !== 1 || last_y !== 8'h0F) begin errors++; $display("FAIL misplaced_frame: got %0d pulses y=%h required 1 pulse y=0f", n_yv, last_y); end
    clear_counts();
    send_frame(8'h81, 8'h01);
    checks++; if (n_se !== 0 || last_y !== 8'h81) begin errors++; $display("FAIL realigned_frame: got err=%0d y=%h required err=0 y=81", n_se, last_y); end
    // A single miss now must not drop lock if the aligned fsync cleared the count.
    clear_counts();
    send_frame(8'h42, 8'h00);
    checks++; if (locked !== 1'b1 || n_se !== 1) begin errors++; $display("FAIL miss_cnt_cleared: got locked=%b err=%0d required locked=1 err=1", locked, n_se); end
    checks++; if (last_y !== 8'h42) begin errors++; $display("FAIL flywheel_frame: got %h required 42", last_y); end
    send_frame(8'h24, 8'h01);
  endtask

  task automatic test_loss();
    clear_counts();
    send_beat(1'b1, 1'b0);
    checks++; if (sync_err !== 1'b1 || locked !== 1'b1) begin errors++; $display("FAIL loss_first_miss: got err=%b locked=%b required err=1 locked=1", sync_err, locked); end
    for (int i = 1; i < 8; i++) send_beat(1'(8'h33 >> i), 1'b0);
    checks++; if (n_yv !== 1 || last_y !== 8'h33) begin errors++; $display("FAIL loss_flywheel_frame: got %0d pulses y=%h required 1 pulse y=33", n_yv, last_y); end
    clear_counts();
    send_beat(1'b1, 1'b0);
    checks++; if (sync_err !== 1'b1 || locked !== 1'b0) begin errors++; $display("FAIL loss_second_miss: got err=%b locked=%b required err=1 locked=0", sync_err, locked); end
    checks++; if (s !== 3'd0) begin errors++; $display("FAIL loss_s: got %0d required 0", s); end
    for (int i = 1; i < 8; i++) send_beat(1'b1, 1'b0);
    idle(2);
    checks++; if (n_yv !== 0) begin errors++; $display("FAIL loss_no_output: got %0d pulses required 0", n_yv); end
    test_acquire(8'hC3, 8'h96, "reacq");
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] v;
    v = 8'hE7;
    clear_counts();
    for (int i = 0; i < 4; i++) send_beat(v[i], i == 0);
    @(negedge clk);
    rst       = 1'b1;
    din       = v[4];
    fsync     = 1'b0;
    din_valid = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (y !== 8'h00)       begin errors++; $display("FAIL midrst_y: got %h required 00", y); end
    checks++; if (y_valid !== 1'b0)  begin errors++; $display("FAIL midrst_y_valid: got %b required 0", y_valid); end
    checks++; if (s !== 3'd0)        begin errors++; $display("FAIL midrst_s: got %0d required 0", s); end
    checks++; if (locked !== 1'b0)   begin errors++; $display("FAIL midrst_locked: got %b required 0", locked); end
    checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL midrst_sync_err: got %b required 0", sync_err); end
    rst = 1'b0;
    for (int i = 5; i < 8; i++) send_beat(v[i], 1'b0);
    idle(2);
    checks++; if (n_yv !== 0) begin errors++; $display("FAIL midrst_partial_emitted: got %0d pulses required 0", n_yv); end
    test_acquire(8'h11, 8'h6B, "relock");
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    n_yv      = 0;
    n_se      = 0;
    last_y    = '0;
    rst       = 1'b1;
    din       = 1'b0;
    din_valid = 1'b0;
    fsync     = 1'b0;

    test_reset();
    test_acquire(8'h3C, 8'hA5, "acq");
    test_gaps();
    test_misplaced_fsync();
    test_loss();
    test_reset_mid_frame();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
